// File: rtl/uart_pkg.sv
// Shared definitions for the UART command framing blocks: FSM states, header fields, error causes.
package uart_pkg;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned RW_BIT            = 7;
    localparam int unsigned ADDR_MSB          = 6;
    localparam int unsigned ADDR_W            = ADDR_MSB + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CSUM,
        ST_ISSUE
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_CSUM,
        ERR_TIMEOUT
    } err_cause_e;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-stream input and register-bus output of the command parser.
interface uart_cmd_parser_if #(
    parameter int unsigned DATA_BYTES = 4
);
    import uart_pkg::*;

    localparam int unsigned DATA_W = 8 * DATA_BYTES;

    logic [7:0]        uart_rx_tdata;
    logic              uart_rx_tvalid;
    logic              uart_rx_tready;
    logic              reg_wr_en;
    logic              reg_rd_en;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wr_data;
    logic              frame_err;
    logic [7:0]        err_count;

    // Byte source / register-file side.
    modport master (
        output uart_rx_tdata, uart_rx_tvalid,
        input  uart_rx_tready, reg_wr_en, reg_rd_en, reg_addr, reg_wr_data,
        input  frame_err, err_count
    );

    // Parser side.
    modport slave (
        input  uart_rx_tdata, uart_rx_tvalid,
        output uart_rx_tready, reg_wr_en, reg_rd_en, reg_addr, reg_wr_data,
        output frame_err, err_count
    );

endinterface

// File: rtl/uart_frame_timeout.sv
// Inter-byte timeout counter; expired is high while the count sits at TIMEOUT_CYCLES-1.
module uart_frame_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 217000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned       CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt_q;
        if (clear) begin
            cnt_nxt = '0;
        end else if (run && (cnt_q != LAST)) begin
            cnt_nxt = cnt_q + CNT_W'(1);
        end
    end

    // expired is registered alongside the count so it always equals (cnt_q == LAST).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            expired <= 1'b0;
        end else begin
            cnt_q   <= cnt_nxt;
            expired <= (cnt_nxt == LAST);
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frame controller: hunts for SYNC, collects header/payload/checksum, issues one register strobe per good frame.
module uart_cmd_parser
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BYTES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 217000,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input logic              clk,
    input logic              rst,
    uart_cmd_parser_if.slave bus
);

    localparam int unsigned DATA_W = 8 * DATA_BYTES;
    localparam int unsigned IDX_W  = $clog2(DATA_BYTES + 1);

    state_e            state_q;
    state_e            state_nxt;
    err_cause_e        err_cause_c;

    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        csum_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] data_q;

    logic              tready_q;
    logic              wr_en_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] reg_addr_q;
    logic [DATA_W-1:0] reg_wr_data_q;
    logic              frame_err_q;
    logic [7:0]        err_count_q;

    logic              wr_nxt;
    logic              rd_nxt;
    logic              accept_c;
    logic [7:0]        byte_c;
    logic              to_clear_c;
    logic              to_run_c;
    logic              to_expired;

    assign accept_c = bus.uart_rx_tvalid & tready_q;
    assign byte_c   = bus.uart_rx_tdata;

    // The counter only runs while a frame is open and the link is quiet.
    assign to_clear_c = accept_c | (state_q == ST_IDLE);
    assign to_run_c   = ~accept_c & ((state_q == ST_HDR) | (state_q == ST_DATA) | (state_q == ST_CSUM));

    uart_frame_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (to_clear_c),
        .run     (to_run_c),
        .expired (to_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // An accepted byte always takes priority over an expiring timeout.
    always_comb begin
        state_nxt   = state_q;
        err_cause_c = ERR_NONE;
        wr_nxt      = 1'b0;
        rd_nxt      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c && (byte_c == SYNC_BYTE)) begin
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                if (accept_c) begin
                    state_nxt = byte_c[RW_BIT] ? ST_DATA : ST_CSUM;
                end else if (to_expired) begin
                    state_nxt   = ST_IDLE;
                    err_cause_c = ERR_TIMEOUT;
                end
            end
            ST_DATA: begin
                if (accept_c) begin
                    if (idx_q == IDX_W'(DATA_BYTES - 1)) begin
                        state_nxt = ST_CSUM;
                    end
                end else if (to_expired) begin
                    state_nxt   = ST_IDLE;
                    err_cause_c = ERR_TIMEOUT;
                end
            end
            ST_CSUM: begin
                if (accept_c) begin
                    if (byte_c == csum_q) begin
                        state_nxt = ST_ISSUE;
                        wr_nxt    = rw_q;
                        rd_nxt    = ~rw_q;
                    end else begin
                        state_nxt   = ST_IDLE;
                        err_cause_c = ERR_CSUM;
                    end
                end else if (to_expired) begin
                    state_nxt   = ST_IDLE;
                    err_cause_c = ERR_TIMEOUT;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Frame datapath: header fields, running checksum, payload shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw_q   <= 1'b0;
            addr_q <= '0;
            csum_q <= '0;
            idx_q  <= '0;
            data_q <= '0;
        end else if (accept_c) begin
            if (state_q == ST_HDR) begin
                rw_q   <= byte_c[RW_BIT];
                addr_q <= byte_c[ADDR_MSB:0];
                csum_q <= byte_c;
                idx_q  <= '0;
            end else if (state_q == ST_DATA) begin
                data_q <= (data_q << 8) | DATA_W'(byte_c);
                csum_q <= csum_q ^ byte_c;
                idx_q  <= idx_q + IDX_W'(1);
            end
        end
    end

    // Registered outputs; reg_addr/reg_wr_data only change on entry to ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tready_q      <= 1'b1;
            wr_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            reg_addr_q    <= '0;
            reg_wr_data_q <= '0;
            frame_err_q   <= 1'b0;
            err_count_q   <= '0;
        end else begin
            tready_q    <= (state_nxt != ST_ISSUE);
            wr_en_q     <= wr_nxt;
            rd_en_q     <= rd_nxt;
            frame_err_q <= (err_cause_c != ERR_NONE);
            if ((err_cause_c != ERR_NONE) && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end
            if (wr_nxt || rd_nxt) begin
                reg_addr_q <= addr_q;
            end
            if (wr_nxt) begin
                reg_wr_data_q <= data_q;
            end
        end
    end

    assign bus.uart_rx_tready = tready_q;
    assign bus.reg_wr_en      = wr_en_q;
    assign bus.reg_rd_en      = rd_en_q;
    assign bus.reg_addr       = reg_addr_q;
    assign bus.reg_wr_data    = reg_wr_data_q;
    assign bus.frame_err      = frame_err_q;
    assign bus.err_count      = err_count_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: table of frames plus timeout, ISSUE back-pressure, reset and saturation sequences.
module tb_uart_cmd_parser;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    int          n_wr = 0;
    int          n_rd = 0;
    int          n_err = 0;
    logic [6:0]  seen_addr = '0;
    logic [31:0] seen_data = '0;
    int          exp_ec = 0;

    typedef struct {
        logic [63:0] bytes;
        int          n;
        bit          wr;
        bit          rd;
        logic [6:0]  addr;
        logic [31:0] data;
        bit          err;
    } vec_t;

    vec_t vecs[7];

    uart_cmd_parser_if #(.DATA_BYTES(4)) bus();

    uart_cmd_parser #(
        .DATA_BYTES     (4),
        .TIMEOUT_CYCLES (100),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: pulse counters plus the strobe/error exclusivity check.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.reg_wr_en) begin
                n_wr      <= n_wr + 1;
                seen_addr <= bus.reg_addr;
                seen_data <= bus.reg_wr_data;
            end
            if (bus.reg_rd_en) begin
                n_rd      <= n_rd + 1;
                seen_addr <= bus.reg_addr;
            end
            if (bus.frame_err) n_err <= n_err + 1;
            if (bus.reg_wr_en || bus.reg_rd_en || bus.frame_err) begin
                checks <= checks + 1;
                if (bus.frame_err && (bus.reg_wr_en || bus.reg_rd_en)) begin
                    errors <= errors + 1;
                    $display("FAIL strobe_vs_err: frame_err and strobe both high at cycle %0d", cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        @(negedge clk);
        bus.uart_rx_tdata  = b;
        bus.uart_rx_tvalid = 1'b1;
        for (int i = 0; i < 8 && !done; i++) begin
            if (bus.uart_rx_tready) done = 1'b1;
            @(posedge clk);
            if (!done) @(negedge clk);
        end
        if (!done) chk("tready_wait", 64'(bus.uart_rx_tready), 64'd1);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.uart_rx_tvalid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic bump_ec();
        exp_ec = (exp_ec == 255) ? 255 : exp_ec + 1;
    endtask

    // Sends one frame, checks strobe latency, then pulse counts and held outputs.
    task automatic run_frame(input vec_t v, input string tag);
        int wr0, rd0, er0;
        wr0 = n_wr; rd0 = n_rd; er0 = n_err;
        for (int i = 0; i < v.n; i++) send_byte(v.bytes[63 - 8*i -: 8]);
        @(negedge clk);
        bus.uart_rx_tvalid = 1'b0;
        chk({tag, "_wr_lat"}, 64'(bus.reg_wr_en), 64'(v.wr));
        chk({tag, "_rd_lat"}, 64'(bus.reg_rd_en), 64'(v.rd));
        chk({tag, "_err_lat"}, 64'(bus.frame_err), 64'(v.err));
        chk({tag, "_tready_issue"}, 64'(bus.uart_rx_tready), 64'(!(v.wr || v.rd)));
        if (v.err) bump_ec();
        idle(4);
        @(negedge clk);
        chk({tag, "_n_wr"}, 64'(n_wr - wr0), 64'(v.wr));
        chk({tag, "_n_rd"}, 64'(n_rd - rd0), 64'(v.rd));
        chk({tag, "_n_err"}, 64'(n_err - er0), 64'(v.err));
        chk({tag, "_err_count"}, 64'(bus.err_count), 64'(exp_ec));
        if (v.wr || v.rd) chk({tag, "_addr"}, 64'(bus.reg_addr), 64'(v.addr));
        if (v.wr) chk({tag, "_data"}, 64'(bus.reg_wr_data), 64'(v.data));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int wr0, rd0, er0, c0;

        vecs[0] = '{64'hA585DEADBEEFA700, 7, 1'b1, 1'b0, 7'h05, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{64'hA512120000000000, 3, 1'b0, 1'b1, 7'h12, 32'h0, 1'b0};
        vecs[2] = '{64'hA585DEADBEEF0000, 7, 1'b0, 1'b0, 7'h00, 32'h0, 1'b1};
        vecs[3] = '{64'h00FF3CA512120000, 6, 1'b0, 1'b1, 7'h12, 32'h0, 1'b0};
        vecs[4] = '{64'hA581A50000012500, 7, 1'b1, 1'b0, 7'h01, 32'hA5000001, 1'b0};
        vecs[5] = '{64'hA57F000000000000, 3, 1'b0, 1'b0, 7'h00, 32'h0, 1'b1};
        vecs[6] = '{64'hA57F7F0000000000, 3, 1'b0, 1'b1, 7'h7F, 32'h0, 1'b0};

        bus.uart_rx_tdata  = 8'h00;
        bus.uart_rx_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", 64'(bus.uart_rx_tready), 64'd1);
        chk("rst_wr", 64'(bus.reg_wr_en), 64'd0);
        chk("rst_rd", 64'(bus.reg_rd_en), 64'd0);
        chk("rst_err", 64'(bus.frame_err), 64'd0);
        chk("rst_ec", 64'(bus.err_count), 64'd0);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) run_frame(vecs[k], $sformatf("vec%0d", k));

        // Timeout: 100 quiet cycles after a partial write frame.
        er0 = n_err;
        send_byte(8'hA5); send_byte(8'h85); send_byte(8'hDE);
        idle(100);
        idle(3);
        @(negedge clk);
        bump_ec();
        chk("timeout_n_err", 64'(n_err - er0), 64'd1);
        chk("timeout_ec", 64'(bus.err_count), 64'(exp_ec));
        run_frame(vecs[0], "after_timeout");

        // Byte landing in the expiry cycle wins over the timeout.
        er0 = n_err; wr0 = n_wr;
        send_byte(8'hA5); send_byte(8'h85); send_byte(8'hDE);
        idle(99);
        send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF); send_byte(8'hA7);
        idle(4);
        @(negedge clk);
        chk("late_byte_n_err", 64'(n_err - er0), 64'd0);
        chk("late_byte_n_wr", 64'(n_wr - wr0), 64'd1);
        chk("late_byte_data", 64'(bus.reg_wr_data), 64'hDEADBEEF);

        // Byte presented during ISSUE is held off one cycle, then accepted.
        rd0 = n_rd;
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h12);
        c0 = cyc;
        send_byte(8'hA5);
        chk("issue_hold_cycles", 64'(cyc - c0), 64'd2);
        send_byte(8'h33); send_byte(8'h33);
        idle(4);
        @(negedge clk);
        chk("issue_hold_n_rd", 64'(n_rd - rd0), 64'd2);
        chk("issue_hold_addr", 64'(bus.reg_addr), 64'h33);

        // Asynchronous reset in the middle of a frame.
        wr0 = n_wr; rd0 = n_rd;
        send_byte(8'hA5); send_byte(8'h85);
        @(negedge clk);
        bus.uart_rx_tvalid = 1'b0;
        #2 rst = 1'b1;
        #1;
        exp_ec = 0;
        chk("midrst_tready", 64'(bus.uart_rx_tready), 64'd1);
        chk("midrst_ec", 64'(bus.err_count), 64'd0);
        chk("midrst_addr", 64'(bus.reg_addr), 64'd0);
        chk("midrst_data", 64'(bus.reg_wr_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_no_strobe", 64'(n_wr - wr0 + n_rd - rd0), 64'd0);
        run_frame(vecs[0], "after_reset");

        // Saturation of the error counter.
        for (int f = 0; f < 300; f++) begin
            send_byte(8'hA5); send_byte(8'h12); send_byte(8'h00);
            bump_ec();
            if (f == 253) begin
                idle(2);
                @(negedge clk);
                chk("ec_254", 64'(bus.err_count), 64'hFE);
            end
        end
        idle(3);
        @(negedge clk);
        chk("ec_saturated", 64'(bus.err_count), 64'(exp_ec));
        chk("ec_saturated_ff", 64'(bus.err_count), 64'hFF);
        run_frame(vecs[1], "after_sat");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
